// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 initiator issuing classic or incrementing-burst cycles,
// streaming write data from a show-ahead FIFO, with a no-ack timeout abort.
module wb_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LENW    = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [DW-1:0]     wr_data,
  input  logic [LENW:0]     wr_level,
  output logic              wr_pop,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);
  localparam int SW = DW / 8;
  localparam int SH = $clog2(SW);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, BUS} state_t;
  state_t r_state, w_next;
  logic r_live, r_we, r_rd_valid, r_done, r_err;
  logic [AW-1:0] r_addr;
  logic [LENW-1:0] r_len, r_beat, w_len;
  logic [SW-1:0] r_sel;
  logic [TW-1:0] r_to;
  logic [DW-1:0] r_rd_data;
  logic w_bus, w_ack, w_last_beat, w_last, w_tout, w_acc;
  assign w_len = (cmd_len == '0) ? LENW'(1) : cmd_len;
  assign w_bus = r_state == BUS;
  assign w_ack = w_bus & wb_ack_i;
  assign w_last_beat = r_beat == r_len - LENW'(1);
  assign w_last = w_ack & w_last_beat;
  assign w_tout = w_bus & ~wb_ack_i & (r_to == TW'(TIMEOUT - 1));
  // r_live keeps cmd_ready low while reset is held
  assign cmd_ready = r_live & ~w_bus & ~(cmd_valid & cmd_we & (wr_level < {1'b0, w_len}));
  assign w_acc = cmd_valid & cmd_ready;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = w_bus ? ((w_last | w_tout) ? IDLE : BUS) : (w_acc ? BUS : IDLE);
    wb_cyc_o = w_bus;
    wb_stb_o = w_bus;
    wb_we_o = w_bus & r_we;
    wb_addr_o = w_bus ? r_addr + (AW'(r_beat) << SH) : '0;
    wb_dat_o = (w_bus & r_we) ? wr_data : '0;
    wb_sel_o = w_bus ? r_sel : '0;
    wb_cti_o = (!w_bus || r_len == LENW'(1)) ? 3'b000 : (w_last_beat ? 3'b111 : 3'b010);
    wr_pop = w_ack & r_we;
    rd_valid = r_rd_valid;
    rd_data = r_rd_data;
    done = r_done;
    err = r_err;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_live <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_sel <= '0;
      r_beat <= '0;
      r_to <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_acc) begin
        r_we <= cmd_we;
        r_addr <= cmd_addr;
        r_len <= w_len;
        r_sel <= cmd_sel;
        r_beat <= '0;
        r_to <= '0;
      end else if (w_ack) begin
        r_beat <= r_beat + LENW'(1);
        r_to <= '0;
      end else if (w_bus) begin
        r_to <= r_to + TW'(1);
      end
      r_rd_valid <= w_ack & ~r_we;
      r_rd_data <= (w_ack & ~r_we) ? wb_dat_i : '0;
      r_done <= w_last;
      r_err <= w_tout;
    end
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: scoreboard bench with a delay-programmable Wishbone slave model.
module tb_wb_burst_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [31:0] cmd_addr = 0;
  logic [4:0] cmd_len = 0;
  logic [3:0] cmd_sel = 0;
  logic [31:0] wr_data = 32'h5000_0000;
  logic [5:0] wr_level = 6'd20;
  logic wr_pop, rd_valid, done, err;
  logic [31:0] rd_data;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 0;
  logic [31:0] wb_addr_o, wb_dat_o, wb_dat_i = 0;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_cti_o;

  wb_burst_master #(.AW(32), .DW(32), .LENW(5), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_level(wr_level), .wr_pop(wr_pop), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [2:0] c; logic [3:0] s; logic [31:0] d;} beat_t;
  beat_t exp_q[$];
  logic [31:0] rd_q[$];
  beat_t b;
  int n_chk = 0, n_pass = 0;
  int n_pop = 0, n_done = 0, n_err = 0, n_rdv = 0, n_cyc = 0;
  int d0, e0, p0, r0, c0;
  int ack_dly = 0, cnt = 0;
  bit no_ack = 0, pop_pend = 0, stb_bad = 0, rdv_at_done = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F96;
  endfunction

  // slave model and monitor: ack decided on negedge, outputs sampled 1ns later
  always @(negedge clk) begin
    if (pop_pend) wr_data = wr_data + 32'd1;
    pop_pend = 0;
    if (wb_cyc_o && !no_ack && cnt >= ack_dly) begin
      wb_ack_i = 1;
      wb_dat_i = mem(wb_addr_o);
      cnt = 0;
    end else begin
      wb_ack_i = 0;
      cnt = wb_cyc_o ? cnt + 1 : 0;
    end
    #1;
    if (wb_stb_o !== wb_cyc_o) stb_bad = 1;
    if (wb_cyc_o) n_cyc++;
    if (wb_cyc_o && wb_ack_i) begin
      if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        b = exp_q.pop_front();
        chk("addr", wb_addr_o, b.a);
        chk("cti", wb_cti_o, b.c);
        chk("sel", wb_sel_o, b.s);
        chk("wdat", wb_dat_o, b.d);
      end
    end
    if (wr_pop) begin n_pop++; pop_pend = 1; end
    if (rd_valid) begin
      n_rdv++;
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rdata", rd_data, rd_q.pop_front());
    end
    if (done) begin n_done++; rdv_at_done = rd_valid; end
    if (err) n_err++;
    if (done && err) chk("done_and_err", 1, 0);
  end

  task automatic snap();
    d0 = n_done; e0 = n_err; p0 = n_pop; r0 = n_rdv; c0 = n_cyc;
  endtask

  task automatic push_exp(bit we, logic [31:0] a, logic [4:0] len, logic [3:0] s);
    int el = (len == 0) ? 1 : int'(len);
    logic [2:0] c;
    for (int i = 0; i < el; i++) begin
      c = (el == 1) ? 3'b000 : ((i == el - 1) ? 3'b111 : 3'b010);
      exp_q.push_back('{a + 32'(i * 4), c, s, we ? wr_data + 32'(i) : 32'd0});
      if (!we) rd_q.push_back(mem(a + 32'(i * 4)));
    end
  endtask

  task automatic wait_accept();
    int k = 0;
    #2;
    while (!cmd_ready && k < 50) begin @(negedge clk); #2; k++; end
    chk("accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic issue(bit we, logic [31:0] a, logic [4:0] len, logic [3:0] s, bit scored);
    if (scored) push_exp(we, a, len, s);
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_sel = s;
    wait_accept();
  endtask

  task automatic wait_end();
    int k = 0;
    while (n_done == d0 && n_err == e0 && k < 200) begin @(negedge clk); #2; k++; end
    chk("end_in_time", k < 200, 1);
    @(negedge clk); #2;
    chk("cyc_low_after", wb_cyc_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    rst = 0;
    @(negedge clk); #2;
    chk("ready_after_rst", cmd_ready, 1);
    // reset in the middle of an 8-beat read
    snap();
    issue(0, 32'h200, 5'd8, 4'hF, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    @(negedge clk); #2;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_stb", wb_stb_o, 0);
    chk("mid_rst_addr", wb_addr_o, 0);
    chk("mid_rst_cti", wb_cti_o, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_rdv", rd_valid, 0);
    rst = 0;
    exp_q.delete(); rd_q.delete();
    @(negedge clk); #2;
    chk("mid_rst_ready_back", cmd_ready, 1);
    chk("mid_rst_no_done_err", n_done + n_err - d0 - e0, 0);
    // single read, slave acks 2 cycles after stb
    ack_dly = 2; snap();
    issue(0, 32'h100, 5'd1, 4'hF, 1);
    wait_end();
    chk("single_done", n_done - d0, 1);
    chk("single_rdv", n_rdv - r0, 1);
    chk("single_done_with_rdv", rdv_at_done, 1);
    chk("single_cyc_len", n_cyc - c0, 3);
    // 4-beat write burst, ack every cycle
    ack_dly = 0; stb_bad = 0; snap();
    issue(1, 32'h1000, 5'd4, 4'h3, 1);
    wait_end();
    chk("wburst_pops", n_pop - p0, 4);
    chk("wburst_done", n_done - d0, 1);
    chk("wburst_cyc_len", n_cyc - c0, 4);
    chk("wburst_stb_eq_cyc", stb_bad, 0);
    // write held off by insufficient FIFO level
    snap();
    push_exp(1, 32'h2000, 5'd4, 4'hF);
    @(negedge clk);
    wr_level = 6'd3;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h2000; cmd_len = 5'd4; cmd_sel = 4'hF;
    repeat (5) @(negedge clk);
    #2;
    chk("lvl_ready_low", cmd_ready, 0);
    chk("lvl_no_bus", n_cyc - c0, 0);
    wr_level = 6'd4;
    wait_accept();
    #2;
    chk("lvl_cyc_next", wb_cyc_o, 1);
    wait_end();
    chk("lvl_pops", n_pop - p0, 4);
    chk("lvl_done", n_done - d0, 1);
    wr_level = 6'd20;
    // slave never acks
    no_ack = 1; snap();
    issue(0, 32'h400, 5'd2, 4'hF, 0);
    wait_end();
    chk("to_cyc_len", n_cyc - c0, 16);
    chk("to_err", n_err - e0, 1);
    chk("to_no_done", n_done - d0, 0);
    chk("to_no_rdv", n_rdv - r0, 0);
    chk("to_no_pop", n_pop - p0, 0);
    no_ack = 0; snap();
    issue(0, 32'h500, 5'd1, 4'hF, 1);
    wait_end();
    chk("after_to_done", n_done - d0, 1);
    // address wrap and zero length
    snap();
    issue(0, 32'hFFFF_FFFC, 5'd2, 4'hF, 1);
    wait_end();
    chk("wrap_rdv", n_rdv - r0, 2);
    snap();
    issue(0, 32'h300, 5'd0, 4'hF, 1);
    wait_end();
    chk("len0_cyc_len", n_cyc - c0, 1);
    chk("len0_done", n_done - d0, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
